div_iter: RTL and testbench



---
 rtl/div_iter_pkg.sv | 12 +
 rtl/div_iter_add.sv | 15 +
 rtl/div_iter.sv | 134 +++++++++++++
 tb/tb_div_iter.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/div_iter_pkg.sv
// Shared configuration for the divide unit: datapath width and divider FSM states.
package div_iter_pkg;

   localparam int unsigned XLEN = 32;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX
   } div_state_t;

endpackage

// File: rtl/div_iter_add.sv
// Parameterised adder/subtractor; op_i=1 selects a_i - b_i.
module div_iter_add #(
   parameter int unsigned Width = 33
) (
   input  logic [Width-1:0] a_i,
   input  logic [Width-1:0] b_i,
   input  logic             op_i,
   output logic [Width-1:0] sum_o
);

   always_comb begin
      sum_o = op_i ? (a_i - b_i) : (a_i + b_i);
   end

endmodule

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider: one quotient bit per clock, sign fix-up in a final cycle.
module div_iter #(
   parameter int unsigned XLEN = div_iter_pkg::XLEN
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            valid_in,
   output logic            ready_out,
   input  logic            sgn,
   input  logic [XLEN-1:0] data0,
   input  logic [XLEN-1:0] data1,
   output logic [XLEN-1:0] quotient,
   output logic [XLEN-1:0] remainder,
   output logic            valid_out
);

   import div_iter_pkg::*;

   localparam int unsigned CntW = $clog2(XLEN);

   div_state_t      state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [XLEN-1:0] rem_q, rem_d;
   // dvd_q shifts the dividend out at the top and the quotient in at the bottom
   logic [XLEN-1:0] dvd_q, dvd_d;
   logic [XLEN-1:0] dvs_q, dvs_d;
   logic            negq_q, negq_d;
   logic            negr_q, negr_d;
   logic [XLEN-1:0] quo_out_q, quo_out_d;
   logic [XLEN-1:0] rem_out_q, rem_out_d;
   logic            valid_q, valid_d;

   logic [XLEN:0]   part;
   logic [XLEN:0]   trial;
   logic [XLEN-1:0] a_mag, b_mag;

   assign part = {rem_q, dvd_q[XLEN-1]};

   div_iter_add #(
      .Width(XLEN + 1)
   ) u_trial_sub (
      .a_i  (part),
      .b_i  ({1'b0, dvs_q}),
      .op_i (1'b1),
      .sum_o(trial)
   );

   always_comb begin
      a_mag = (sgn && data0[XLEN-1]) ? (~data0 + 1'b1) : data0;
      b_mag = (sgn && data1[XLEN-1]) ? (~data1 + 1'b1) : data1;
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rem_d     = rem_q;
      dvd_d     = dvd_q;
      dvs_d     = dvs_q;
      negq_d    = negq_q;
      negr_d    = negr_q;
      quo_out_d = quo_out_q;
      rem_out_d = rem_out_q;
      valid_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (valid_in) begin
               dvd_d   = a_mag;
               dvs_d   = b_mag;
               rem_d   = '0;
               negq_d  = sgn & (data0[XLEN-1] ^ data1[XLEN-1]);
               negr_d  = sgn & data0[XLEN-1];
               cnt_d   = CntW'(XLEN - 1);
               state_d = CALC;
            end
         end
         CALC: begin
            if (!trial[XLEN]) begin
               rem_d = trial[XLEN-1:0];
               dvd_d = {dvd_q[XLEN-2:0], 1'b1};
            end else begin
               rem_d = part[XLEN-1:0];
               dvd_d = {dvd_q[XLEN-2:0], 1'b0};
            end
            cnt_d = cnt_q - CntW'(1);
            if (cnt_q == '0) begin
               state_d = FIX;
            end
         end
         FIX: begin
            // Divide by zero keeps the all-ones quotient regardless of sign
            quo_out_d = (negq_q && (dvs_q != '0)) ? (~dvd_q + 1'b1) : dvd_q;
            rem_out_d = negr_q ? (~rem_q + 1'b1) : rem_q;
            valid_d   = 1'b1;
            state_d   = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         rem_q     <= '0;
         dvd_q     <= '0;
         dvs_q     <= '0;
         negq_q    <= 1'b0;
         negr_q    <= 1'b0;
         quo_out_q <= '0;
         rem_out_q <= '0;
         valid_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rem_q     <= rem_d;
         dvd_q     <= dvd_d;
         dvs_q     <= dvs_d;
         negq_q    <= negq_d;
         negr_q    <= negr_d;
         quo_out_q <= quo_out_d;
         rem_out_q <= rem_out_d;
         valid_q   <= valid_d;
      end
   end

   assign ready_out = (state_q == IDLE);
   assign quotient  = quo_out_q;
   assign remainder = rem_out_q;
   assign valid_out = valid_q;

endmodule

// File: tb/tb_div_iter.sv
// Scoreboard bench for div_iter: issued requests queue expected results, a monitor checks them.
module tb_div_iter;

   localparam int unsigned XLEN = 32;
   localparam int unsigned LATENCY = 33;

   logic            clock;
   logic            reset;
   logic            valid_in;
   logic            ready_out;
   logic            sgn;
   logic [XLEN-1:0] data0;
   logic [XLEN-1:0] data1;
   logic [XLEN-1:0] quotient;
   logic [XLEN-1:0] remainder;
   logic            valid_out;

   div_iter #(
      .XLEN(XLEN)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .valid_in (valid_in),
      .ready_out(ready_out),
      .sgn      (sgn),
      .data0    (data0),
      .data1    (data1),
      .quotient (quotient),
      .remainder(remainder),
      .valid_out(valid_out)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   logic [2*XLEN-1:0] exp_q[$];
   int                acc_q[$];

   task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] expv);
      n_vec++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
      end
   endtask

   // Edge counter plus accept-time capture
   always @(posedge clock) begin
      if (reset && valid_in && ready_out) acc_q.push_back(cyc);
      cyc = cyc + 1;
   end

   always @(negedge clock) begin
      if (valid_out) begin
         logic [2*XLEN-1:0] e;
         int                a;
         if (exp_q.size() == 0 || acc_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_valid: got valid_out=1 expected no result pending");
         end else begin
            e = exp_q.pop_front();
            a = acc_q.pop_front();
            chk("quotient", quotient, e[2*XLEN-1:XLEN]);
            chk("remainder", remainder, e[XLEN-1:0]);
            chk("latency", XLEN'(cyc - a - 1), XLEN'(LATENCY));
            chk("ready_in_valid_cycle", {31'b0, ready_out}, 32'd1);
         end
      end
   end

   function automatic logic [2*XLEN-1:0] model(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                               input logic s);
      logic signed [XLEN-1:0] sa, sb;
      logic [XLEN-1:0]        q, r;
      sa = a;
      sb = b;
      if (b == '0) begin
         q = '1;
         r = a;
      end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         q = 32'h8000_0000;
         r = '0;
      end else if (s) begin
         q = sa / sb;
         r = sa % sb;
      end else begin
         q = a / b;
         r = a % b;
      end
      return {q, r};
   endfunction

   task automatic issue(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input logic s,
                        input logic [2*XLEN-1:0] expv);
      int guard = 0;
      while (!ready_out && guard < 100) begin
         @(negedge clock);
         guard++;
      end
      if (!ready_out) begin
         n_vec++;
         n_err++;
         $display("FAIL ready_timeout: got ready_out=0 expected 1 within 100 cycles");
      end
      data0    = a;
      data1    = b;
      sgn      = s;
      valid_in = 1'b1;
      exp_q.push_back(expv);
      @(negedge clock);
      valid_in = 1'b0;
      data0    = $urandom;
      data1    = $urandom;
      sgn      = 1'($urandom);
      chk("busy_ready", {31'b0, ready_out}, 32'd0);
   endtask

   task automatic drain();
      int guard = 0;
      while (exp_q.size() != 0 && guard < 200) begin
         @(negedge clock);
         guard++;
      end
      chk("drain_pending", XLEN'(exp_q.size()), 32'd0);
   endtask

   initial begin
      int a0;
      reset    = 1'b0;
      valid_in = 1'b0;
      sgn      = 1'b0;
      data0    = '0;
      data1    = '0;
      #1;
      chk("rst_ready", {31'b0, ready_out}, 32'd1);
      chk("rst_valid", {31'b0, valid_out}, 32'd0);
      chk("rst_quotient", quotient, 32'd0);
      chk("rst_remainder", remainder, 32'd0);
      repeat (2) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);

      issue(32'd100, 32'd7, 1'b0, {32'h0000_000E, 32'h0000_0002});
      issue(32'hFFFF_FFF9, 32'h0000_0002, 1'b1, {32'hFFFF_FFFD, 32'hFFFF_FFFF});
      issue(32'h1234_5678, 32'h0, 1'b0, {32'hFFFF_FFFF, 32'h1234_5678});
      issue(32'h8000_0005, 32'h0, 1'b1, {32'hFFFF_FFFF, 32'h8000_0005});
      issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'h8000_0000, 32'h0000_0000});
      issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, {32'h0000_0000, 32'h8000_0000});
      issue(32'd7, 32'hFFFF_FFFE, 1'b1, {32'hFFFF_FFFD, 32'h0000_0001});
      issue(32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, {32'h0000_0003, 32'hFFFF_FFFF});
      issue(32'd5, 32'd9, 1'b0, {32'h0, 32'h5});
      issue(32'hFFFF_FFFF, 32'd1, 1'b0, {32'hFFFF_FFFF, 32'h0});
      drain();

      // Abort mid-operation
      issue(32'h0000_1000, 32'd3, 1'b0, {32'h0, 32'h0});
      a0 = acc_q[0];
      while (cyc < a0 + 10) @(negedge clock);
      reset = 1'b0;
      exp_q.delete();
      acc_q.delete();
      #1;
      chk("abort_ready", {31'b0, ready_out}, 32'd1);
      chk("abort_valid", {31'b0, valid_out}, 32'd0);
      chk("abort_quotient", quotient, 32'd0);
      chk("abort_remainder", remainder, 32'd0);
      repeat (2) @(negedge clock);
      reset = 1'b1;
      repeat (40) @(negedge clock);
      issue(32'd9, 32'd3, 1'b0, {32'd3, 32'd0});
      drain();

      for (int i = 0; i < 300; i++) begin
         logic [XLEN-1:0] a, b;
         logic            s;
         a = $urandom;
         b = $urandom;
         s = 1'($urandom);
         case ($urandom_range(0, 3))
            0: b = XLEN'($urandom_range(1, 20));
            1: b = -XLEN'($urandom_range(1, 20));
            2: a = XLEN'($urandom_range(0, 1000));
            default: ;
         endcase
         issue(a, b, s, model(a, b, s));
      end
      drain();

      repeat (5) @(negedge clock);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
